// File: rtl/fetch_pc_unit.sv
// Program counter and next-address stage: ret/call/jump/branch redirect plus a return-address stack.
// Latency: a redirect presented in cycle N is visible on pc in cycle N+1; no bubbles or delay slots.
// Backpressure: stall freezes pc, stack, depth, error flags and FSM; only clearErr acts under stall.
// Build option: define STACK_ERR_TRAP_EN to send pc to TRAP_VECTOR on stack overflow/underflow.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 8'hFF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           halt,
  input  logic                           branch,
  input  logic                           branchNe,
  input  logic                           zeroFlag,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_WIDTH-1:0]          target,
  input  logic                           clearErr,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic                           pcValid,
  output logic [$clog2(STACK_DEPTH):0]   stackDepth,
  output logic                           stackOverflow,
  output logic                           stackUnderflow
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] err_pc;
  logic [DEPTH_W-1:0]    depth_dec;
  logic                  br_taken;

  // Wrapping increment doubles as the sequential address and the pushed return address.
  assign pc_inc    = pc_q + ADDR_WIDTH'(1);
  assign depth_dec = depth_q - DEPTH_W'(1);
  assign br_taken  = branch & (zeroFlag ^ branchNe);

`ifdef STACK_ERR_TRAP_EN
  // Stack misuse vectors to the trap handler.
  assign err_pc = TRAP_VECTOR;
`else
  // Stack misuse simply falls through to the next sequential instruction.
  assign err_pc = pc_inc;
  logic unused_trap;
  assign unused_trap = ^TRAP_VECTOR;
`endif

  // Next-state: FSM, strobe priority decode, stack push/pop and sticky error flags.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    stack_d = stack_q;
    // Clear acts even under stall; a same-edge error event below re-sets the flag.
    ovf_d   = ovf_q & ~clearErr;
    unf_d   = unf_q & ~clearErr;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALTED;
          end
          if (ret) begin
            if (depth_q != '0) begin
              pc_d    = stack_q[depth_dec[PTR_W-1:0]];
              depth_d = depth_dec;
            end else begin
              pc_d  = err_pc;
              unf_d = 1'b1;
            end
          end else if (call) begin
            if (depth_q != DEPTH_FULL) begin
              stack_d[depth_q[PTR_W-1:0]] = pc_inc;
              pc_d    = target;
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              pc_d  = err_pc;
              ovf_d = 1'b1;
            end
          end else if (jump || br_taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        // HALTED (and any unreachable encoding) parks until reset.
        state_d = ST_HALTED;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset: entries above depth are never read.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc             = pc_q;
  assign pcValid        = (state_q == ST_RUN);
  assign stackDepth     = depth_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expected values.
module tb_fetch_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, halt = 1'b0, branch = 1'b0, branchNe = 1'b0, zeroFlag = 1'b0;
  logic       jump = 1'b0, call = 1'b0, ret = 1'b0, clearErr = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] pc;
  logic       pcValid, stackOverflow, stackUnderflow;
  logic [3:0] stackDepth;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

`ifdef STACK_ERR_TRAP_EN
  localparam logic [7:0] OVF_PC = 8'hFF;
  localparam logic [7:0] UNF_PC = 8'hFF;
  localparam logic [7:0] UNF2_PC = 8'hFF;
`else
  localparam logic [7:0] OVF_PC = 8'h91;
  localparam logic [7:0] UNF_PC = 8'h08;
  localparam logic [7:0] UNF2_PC = 8'h09;
`endif

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
    .branch(branch), .branchNe(branchNe), .zeroFlag(zeroFlag),
    .jump(jump), .call(call), .ret(ret), .target(target), .clearErr(clearErr),
    .pc(pc), .pcValid(pcValid), .stackDepth(stackDepth),
    .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] epc, input logic [3:0] edepth);
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, epc});
    chk({tag, "_depth"}, {28'd0, stackDepth}, {28'd0, edepth});
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_valid", {31'd0, pcValid}, 32'h0);
    chk("rst_depth", {28'd0, stackDepth}, 32'h0);
    chk("rst_ovf", {31'd0, stackOverflow}, 32'h0);
    chk("rst_unf", {31'd0, stackUnderflow}, 32'h0);

    // Release: one invalid cycle then 0,1,2,3
    rst_n = 1'b1;
    chk("rel_valid0", {31'd0, pcValid}, 32'h0);
    step(); chk("idle_valid1", {31'd0, pcValid}, 32'h1); chk_pc("seq0", 8'h00, 4'd0);
    step(); chk_pc("seq1", 8'h01, 4'd0);
    step(); chk_pc("seq2", 8'h02, 4'd0);
    step(); chk_pc("seq3", 8'h03, 4'd0);

    // Jumps and branches
    jump = 1'b1; target = 8'h10; step(); chk_pc("jmp10", 8'h10, 4'd0);
    target = 8'h40; step(); chk_pc("jmp40", 8'h40, 4'd0);
    jump = 1'b0;
    branch = 1'b1; branchNe = 1'b0; zeroFlag = 1'b1; target = 8'h20;
    step(); chk_pc("beq_taken", 8'h20, 4'd0);
    branchNe = 1'b1; zeroFlag = 1'b1; step(); chk_pc("bne_not", 8'h21, 4'd0);
    branchNe = 1'b0; zeroFlag = 1'b0; step(); chk_pc("beq_not", 8'h22, 4'd0);
    branchNe = 1'b1; zeroFlag = 1'b0; target = 8'h30; step(); chk_pc("bne_taken", 8'h30, 4'd0);
    branch = 1'b0; branchNe = 1'b0;

    // Call / return
    jump = 1'b1; target = 8'h05; step(); chk_pc("jmp05", 8'h05, 4'd0);
    jump = 1'b0; call = 1'b1; target = 8'h80; step(); chk_pc("call80", 8'h80, 4'd1);
    call = 1'b0;
    step(); chk_pc("sub81", 8'h81, 4'd1);
    step(); chk_pc("sub82", 8'h82, 4'd1);
    step(); chk_pc("sub83", 8'h83, 4'd1);
    ret = 1'b1; step(); chk_pc("ret06", 8'h06, 4'd0);
    ret = 1'b0;

    // Nested calls up to full, then overflow
    call = 1'b1; target = 8'h90;
    for (int i = 0; i < 8; i++) step();
    chk_pc("full", 8'h90, 4'd8);
    chk("full_ovf", {31'd0, stackOverflow}, 32'h0);
    step(); chk_pc("ovf", OVF_PC, 4'd8);
    chk("ovf_flag", {31'd0, stackOverflow}, 32'h1);

    // call+ret together: ret only
    ret = 1'b1; step(); chk_pc("callret", 8'h91, 4'd7);
    call = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_pc("drain", 8'h91, 4'd1);
    step(); chk_pc("ret07", 8'h07, 4'd0);
    step(); chk_pc("unf", UNF_PC, 4'd0);
    chk("unf_flag", {31'd0, stackUnderflow}, 32'h1);
    chk("ovf_sticky", {31'd0, stackOverflow}, 32'h1);

    // Clear with a same-edge underflow: set wins for underflow
    clearErr = 1'b1; step();
    chk_pc("unf2", UNF2_PC, 4'd0);
    chk("setwins_unf", {31'd0, stackUnderflow}, 32'h1);
    chk("clr_ovf", {31'd0, stackOverflow}, 32'h0);
    ret = 1'b0; stall = 1'b1; step();
    chk_pc("clr_stall", UNF2_PC, 4'd0);
    chk("clr_unf", {31'd0, stackUnderflow}, 32'h0);
    clearErr = 1'b0; stall = 1'b0;

    // Wrap-around
    jump = 1'b1; target = 8'hFF; step(); chk_pc("jmpFF", 8'hFF, 4'd0);
    jump = 1'b0; step(); chk_pc("wrap", 8'h00, 4'd0);
    jump = 1'b1; step(); chk_pc("jmpFF2", 8'hFF, 4'd0);
    jump = 1'b0; call = 1'b1; target = 8'h50; step(); chk_pc("callFF", 8'h50, 4'd1);
    call = 1'b0; ret = 1'b1; step(); chk_pc("retwrap", 8'h00, 4'd0);

    // call beats jump
    ret = 1'b0; call = 1'b1; jump = 1'b1; target = 8'h33; step(); chk_pc("call_jmp", 8'h33, 4'd1);
    call = 1'b0; jump = 1'b0; ret = 1'b1; step(); chk_pc("ret01", 8'h01, 4'd0);
    ret = 1'b0;

    // Stall holds everything and masks halt
    stall = 1'b1; halt = 1'b1; jump = 1'b1; target = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pc("stall", 8'h01, 4'd0);
      chk("stall_valid", {31'd0, pcValid}, 32'h1);
    end
    stall = 1'b0; halt = 1'b0; step(); chk_pc("post_stall", 8'h77, 4'd0);
    jump = 1'b0; call = 1'b1; target = 8'h60; step(); chk_pc("call60", 8'h60, 4'd1);
    call = 1'b0;

    // Asynchronous reset mid-run
    rst_n = 1'b0; #2;
    chk_pc("arst", 8'h00, 4'd0);
    chk("arst_valid", {31'd0, pcValid}, 32'h0);
    #1 rst_n = 1'b1;
    step(); chk("rerun_valid", {31'd0, pcValid}, 32'h1); chk_pc("rerun", 8'h00, 4'd0);

    // Halt: the halting edge still advances pc, then everything freezes
    halt = 1'b1; step();
    chk("halt_valid", {31'd0, pcValid}, 32'h0);
    chk_pc("halt", 8'h01, 4'd0);
    halt = 1'b0; jump = 1'b1; target = 8'h44;
    step(); step();
    chk_pc("halted", 8'h01, 4'd0);
    chk("halted_valid", {31'd0, pcValid}, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
